// File: rtl/fp_pkg.sv
// fp_pkg: shared floating-point constants and types for the fpUnit
// narrowing converters.
//   - rounding-mode encodings (RM_*)
//   - exponent biases and field widths for binary128 / binary32
//   - single-precision special encodings (infinity, quiet NaN, max finite)
//   - kind_e / algn_t: the aligned operand handed from the align stage
//     to the rounding stage
package fp_pkg;

  localparam logic [2:0] RM_RNE = 3'd0;
  localparam logic [2:0] RM_RTZ = 3'd1;
  localparam logic [2:0] RM_RDN = 3'd2;
  localparam logic [2:0] RM_RUP = 3'd3;
  localparam logic [2:0] RM_RMM = 3'd4;

  localparam int QUAD_BIAS = 16383;
  localparam int SGL_BIAS  = 127;
  localparam int BIAS_DIFF = 16256;

  localparam int QUAD_EXP_W  = 15;
  localparam int QUAD_FRAC_W = 112;
  localparam int SGL_EXP_W   = 8;
  localparam int SGL_FRAC_W  = 23;

  localparam logic [31:0] SGL_INF  = 32'h7F80_0000;
  localparam logic [31:0] SGL_QNAN = 32'h7FC0_0000;
  localparam logic [31:0] SGL_MAXF = 32'h7F7F_FFFF;

  // Operand class after alignment; only K_NUM goes through the adder.
  typedef enum logic [2:0] {
    K_NUM   = 3'd0,
    K_HUGE  = 3'd1,
    K_FLUSH = 3'd2,
    K_NAN   = 3'd3,
    K_INF   = 3'd4,
    K_ZERO  = 3'd5
  } kind_e;

  typedef struct packed {
    kind_e                 kind;
    logic                  sign;
    logic [SGL_EXP_W-1:0]  exp;
    logic [SGL_FRAC_W-1:0] mant;
    logic                  guard;
    logic                  sticky;
    logic                  tiny;     // tiny before rounding
    logic                  snan;
    logic [21:0]           payload;  // quad fraction[110:89] for NaNs
  } algn_t;

endpackage

// File: rtl/fcvtqs_round.sv
// fcvtqs_round: combinational rounding / overflow / flag logic for a
// narrowing conversion to binary32.
// Ports:
//   kind, sign, exp, mant, guard, sticky, tiny, snan, payload : aligned operand
//   rm                                                        : rounding mode
//   res                                                       : binary32 result
//   inexact, overflow, underflow, invalid                     : IEEE flags
module fcvtqs_round
  import fp_pkg::*;
(
  input  logic [2:0]  kind,
  input  logic        sign,
  input  logic [7:0]  exp,
  input  logic [22:0] mant,
  input  logic        guard,
  input  logic        sticky,
  input  logic        tiny,
  input  logic        snan,
  input  logic [21:0] payload,
  input  logic [2:0]  rm,
  output logic [31:0] res,
  output logic        inexact,
  output logic        overflow,
  output logic        underflow,
  output logic        invalid
);

  function automatic logic round_up(input logic [2:0] m, input logic s,
                                    input logic g, input logic st,
                                    input logic lsb);
    case (m)
      RM_RTZ:  round_up = 1'b0;
      RM_RDN:  round_up = s & (g | st);
      RM_RUP:  round_up = ~s & (g | st);
      RM_RMM:  round_up = g;
      default: round_up = g & (st | lsb);
    endcase
  endfunction

  // Directed modes rounding toward zero saturate at max finite.
  function automatic logic ovf_to_max(input logic [2:0] m, input logic s);
    ovf_to_max = (m == RM_RTZ) || (m == RM_RDN && !s) || (m == RM_RUP && s);
  endfunction

  logic        inc;
  logic [23:0] sig;
  logic [8:0]  expr;
  logic [31:0] ovf_res;

  assign inc  = round_up(rm, sign, guard, sticky, mant[0]);
  // Carry out of the mantissa bumps the exponent: a subnormal 0x7FFFFF
  // becomes the minimum normal, exponent 254 overflows to 255.
  assign sig  = {1'b0, mant} + {23'd0, inc};
  assign expr = {1'b0, exp} + {8'd0, sig[23]};
  assign ovf_res = {sign, ovf_to_max(rm, sign) ? SGL_MAXF[30:0] : SGL_INF[30:0]};

  always_comb begin
    res       = 32'd0;
    inexact   = 1'b0;
    overflow  = 1'b0;
    underflow = 1'b0;
    invalid   = 1'b0;
    case (kind_e'(kind))
      K_NUM: begin
        if (expr == 9'd255) begin
          res      = ovf_res;
          overflow = 1'b1;
          inexact  = 1'b1;
        end else begin
          res       = {sign, expr[7:0], sig[22:0]};
          inexact   = guard | sticky;
          underflow = tiny & (guard | sticky);
        end
      end
      K_HUGE: begin
        res      = ovf_res;
        overflow = 1'b1;
        inexact  = 1'b1;
      end
      K_FLUSH: begin
        res       = {sign, 31'd0};
        underflow = 1'b1;
        inexact   = 1'b1;
      end
      K_NAN: begin
        res     = {sign, SGL_QNAN[30:0]} | {10'd0, payload};
        invalid = snan;
      end
      K_INF:   res = {sign, SGL_INF[30:0]};
      K_ZERO:  res = {sign, 31'd0};
      default: res = 32'd0;
    endcase
  end

endmodule

// File: rtl/fcvtqs_pipe.sv
// fcvtqs_pipe: pipelined binary128 -> binary32 converter with IEEE flags.
// An ld sampled at enabled edge N gives done=1 after enabled edge N+3.
// Ports:
//   clk, rst (sync, active-high), ce (global pipeline enable)
//   ld, a[FPWID-1:0], rm[2:0] : new operation (sampled when ce=1)
//   o[31:0], done             : result, valid for the operation loaded
//   inexact, overflow, underflow, invalid : IEEE flags, valid with done
// Build option: FCVTQS_DENORM_EN defined produces single subnormals for
// tiny results; undefined flushes them to signed zero (no shifter).
module fcvtqs_pipe
  import fp_pkg::*;
#(
  parameter int FPWID = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             ld,
  input  logic [FPWID-1:0] a,
  input  logic [2:0]       rm,
  output logic [31:0]      o,
  output logic             done,
  output logic             inexact,
  output logic             overflow,
  output logic             underflow,
  output logic             invalid
);

  logic                     vld_p0, vld_p1, vld_p2;
  logic [FPWID-1:0]         a_p0;
  logic [2:0]               rm_p0, rm_p1, rm_p2;

  logic                     sign_p1, nan_p1, inf_p1, zero_p1;
  logic signed [16:0]       e_p1;
  logic [QUAD_FRAC_W-1:0]   frac_p1;
`ifdef FCVTQS_DENORM_EN
  logic                     den_p1;
`endif

  algn_t                    algn_d, algn_p2;

  logic [31:0]              res_d;
  logic                     nx_d, of_d, uf_d, nv_d;

  // ---- stage 1: decompose the captured operand ----
  logic [QUAD_EXP_W-1:0]    xa_d;
  logic [QUAD_FRAC_W-1:0]   frac_d;
  logic signed [16:0]       e_d;

  assign xa_d   = a_p0[126:112];
  assign frac_d = a_p0[111:0];
  // 17-bit signed so xa=0 yields -16256 without wrapping.
  assign e_d    = $signed({2'b00, xa_d}) - $signed(17'(BIAS_DIFF));

  // ---- stage 2: align into single-precision mantissa/guard/sticky ----
`ifdef FCVTQS_DENORM_EN
  logic signed [16:0]       shamt_s;
  logic [4:0]               shamt;
  logic [49:0]              shbuf;

  assign shamt_s = 17'sd1 - e_p1;
  // Beyond 26 every significant bit is already in sticky.
  assign shamt   = (shamt_s > 17'sd26) ? 5'd26 : shamt_s[4:0];
  // Bit 49 lands on the subnormal mantissa MSB after a shift of one.
  assign shbuf   = 50'({~den_p1, frac_p1[111:88], 26'd0} >> shamt);
`endif

  always_comb begin
    algn_d         = '0;
    algn_d.kind    = K_NUM;
    algn_d.sign    = sign_p1;
    algn_d.snan    = ~frac_p1[111];
    algn_d.payload = frac_p1[110:89];
    if (nan_p1)
      algn_d.kind = K_NAN;
    else if (inf_p1)
      algn_d.kind = K_INF;
    else if (zero_p1)
      algn_d.kind = K_ZERO;
    else if (e_p1 >= 17'sd255)
      algn_d.kind = K_HUGE;
    else if (e_p1 >= 17'sd1) begin
      algn_d.exp    = e_p1[7:0];
      algn_d.mant   = frac_p1[111:89];
      algn_d.guard  = frac_p1[88];
      algn_d.sticky = |frac_p1[87:0];
    end else begin
      algn_d.tiny = 1'b1;
`ifdef FCVTQS_DENORM_EN
      algn_d.exp    = 8'd0;
      algn_d.mant   = shbuf[49:27];
      algn_d.guard  = shbuf[26];
      algn_d.sticky = (|shbuf[25:0]) | (|frac_p1[87:0]);
`else
      algn_d.kind = K_FLUSH;
`endif
    end
  end

  // ---- stage 3: round ----
  fcvtqs_round u_round (
    .kind      (algn_p2.kind),
    .sign      (algn_p2.sign),
    .exp       (algn_p2.exp),
    .mant      (algn_p2.mant),
    .guard     (algn_p2.guard),
    .sticky    (algn_p2.sticky),
    .tiny      (algn_p2.tiny),
    .snan      (algn_p2.snan),
    .payload   (algn_p2.payload),
    .rm        (rm_p2),
    .res       (res_d),
    .inexact   (nx_d),
    .overflow  (of_d),
    .underflow (uf_d),
    .invalid   (nv_d)
  );

  // Control: valids and the visible result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0    <= 1'b0;
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      done      <= 1'b0;
      o         <= 32'd0;
      inexact   <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      invalid   <= 1'b0;
    end else if (ce) begin
      vld_p0 <= ld;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
      done   <= vld_p2;
      // Bubbles leave the last result on o.
      if (vld_p2) begin
        o         <= res_d;
        inexact   <= nx_d;
        overflow  <= of_d;
        underflow <= uf_d;
        invalid   <= nv_d;
      end
    end
  end

  // Data path registers.
  always_ff @(posedge clk) begin
    if (ce) begin
      a_p0    <= a;
      rm_p0   <= rm;

      sign_p1 <= a_p0[127];
      e_p1    <= e_d;
      frac_p1 <= frac_d;
      nan_p1  <= (xa_d == 15'h7FFF) && (frac_d != '0);
      inf_p1  <= (xa_d == 15'h7FFF) && (frac_d == '0);
      zero_p1 <= (xa_d == 15'h0000) && (frac_d == '0);
`ifdef FCVTQS_DENORM_EN
      den_p1  <= (xa_d == 15'h0000) && (frac_d != '0);
`endif
      rm_p1   <= rm_p0;

      algn_p2 <= algn_d;
      rm_p2   <= rm_p1;
    end
  end

endmodule
